// File: rtl/present_pkg.sv
// Shared PRESENT-80 definitions: widths, key/round-key types and the 4-bit S-box pair.
package present_pkg;

    localparam int unsigned KEY_W    = 80;
    localparam int unsigned RK_W     = 64;
    localparam int unsigned NUM_RK   = 32;
    localparam int unsigned LAST_CNT = 31;
    localparam int unsigned IDX_W    = 6;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [RK_W-1:0]  rk_t;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] sbox4_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/present_inv_key_sched_if.sv
// Key-in and round-key-out handshakes of the inverse key schedule.
interface present_inv_key_sched_if;
    import present_pkg::*;

    key_t             key_in;
    logic             key_valid;
    logic             key_ready;
    rk_t              rk_out;
    logic [IDX_W-1:0] rk_idx;
    logic             rk_valid;
    logic             rk_ready;
    logic             rk_last;
    logic             busy;

    modport master (
        output key_in, key_valid, rk_ready,
        input  key_ready, rk_out, rk_idx, rk_valid, rk_last, busy
    );

    modport slave (
        input  key_in, key_valid, rk_ready,
        output key_ready, rk_out, rk_idx, rk_valid, rk_last, busy
    );

endinterface

// File: rtl/present_key_step.sv
// One PRESENT-80 key-schedule step: forward F(K,c) when inv=0, its exact inverse G(K,c) when inv=1.
module present_key_step
    import present_pkg::*;
(
    input  key_t       key,
    input  logic [4:0] cnt,
    input  logic       inv,
    output key_t       key_next
);

    key_t fwd;
    key_t bwd;

    always_comb begin
        fwd          = {key[18:0], key[79:19]};
        fwd[79:76]   = sbox4(fwd[79:76]);
        fwd[19:15]   = fwd[19:15] ^ cnt;

        bwd          = key;
        bwd[19:15]   = bwd[19:15] ^ cnt;
        bwd[79:76]   = sbox4_inv(bwd[79:76]);
        bwd          = {bwd[60:0], bwd[79:61]};

        key_next     = inv ? bwd : fwd;
    end

endmodule

// File: rtl/present_inv_key_sched.sv
// PRESENT-80 decryption key schedule: expands the key forward to K32, then streams round keys 32..1.
module present_inv_key_sched
    import present_pkg::*;
(
    input logic                    clock,
    input logic                    reset_n,
    present_inv_key_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StExpand, StEmit} state_e;

    state_e           state_q;
    key_t             k_q;
    logic [4:0]       cnt_q;
    logic [IDX_W-1:0] rk_idx_q;
    rk_t              rk_out_q;
    logic             rk_valid_q;
    logic             rk_last_q;
    logic             busy_q;
    logic             key_ready_q;

    logic             step_inv;
    logic [4:0]       step_cnt;
    key_t             k_step;

    // In EMIT the inverse step undoes forward step r-1; r==32 wraps to 31 in 5 bits.
    assign step_inv = (state_q == StEmit);
    assign step_cnt = step_inv ? (rk_idx_q[4:0] - 5'd1) : cnt_q;

    present_key_step u_step (
        .key      (k_q),
        .cnt      (step_cnt),
        .inv      (step_inv),
        .key_next (k_step)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            k_q         <= '0;
            cnt_q       <= '0;
            rk_idx_q    <= '0;
            rk_out_q    <= '0;
            rk_valid_q  <= 1'b0;
            rk_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            key_ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.key_valid) begin
                        k_q         <= bus.key_in;
                        cnt_q       <= 5'd1;
                        busy_q      <= 1'b1;
                        key_ready_q <= 1'b0;
                        state_q     <= StExpand;
                    end
                end
                StExpand: begin
                    k_q <= k_step;
                    if (cnt_q == 5'(LAST_CNT)) begin
                        cnt_q    <= '0;
                        rk_idx_q <= IDX_W'(NUM_RK);
                        state_q  <= StEmit;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                StEmit: begin
                    if (!rk_valid_q) begin
                        // Transition cycle: present K32 as the first round key.
                        rk_valid_q <= 1'b1;
                        rk_out_q   <= k_q[KEY_W-1:KEY_W-RK_W];
                    end else if (bus.rk_ready) begin
                        if (rk_idx_q == IDX_W'(1)) begin
                            rk_valid_q  <= 1'b0;
                            rk_last_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            key_ready_q <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            k_q       <= k_step;
                            rk_out_q  <= k_step[KEY_W-1:KEY_W-RK_W];
                            rk_idx_q  <= rk_idx_q - IDX_W'(1);
                            rk_last_q <= (rk_idx_q == IDX_W'(2));
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.key_ready = key_ready_q;
    assign bus.rk_out    = rk_out_q;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.rk_valid  = rk_valid_q;
    assign bus.rk_last   = rk_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_present_inv_key_sched.sv
// Directed bench for present_inv_key_sched with a forward-schedule model feeding a scoreboard queue.
module tb_present_inv_key_sched;
    import present_pkg::*;

    typedef struct packed {
        logic [5:0] idx;
        rk_t        rk;
        logic       last;
    } exp_t;

    logic clock;
    logic reset_n;
    int   n_assert;
    int   n_fail;
    exp_t sb[$];
    rk_t  got_rk2;
    rk_t  got_rk1;
    logic [3:0] sbox_tab [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                  4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    present_inv_key_sched_if bus ();

    present_inv_key_sched dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic key_t fwd(input key_t k, input logic [4:0] c);
        key_t r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox_tab[r[79:76]];
        r[19:15]   = r[19:15] ^ c;
        return r;
    endfunction

    task automatic push_expect(input key_t key);
        key_t k;
        rk_t  rks [33];
        k      = key;
        rks[0] = '0;
        rks[1] = k[79:16];
        for (int i = 1; i <= 31; i++) begin
            k          = fwd(k, 5'(i));
            rks[i + 1] = k[79:16];
        end
        for (int r = 32; r >= 1; r--) sb.push_back('{idx: 6'(r), rk: rks[r], last: (r == 1)});
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rk_out"}, 80'(bus.rk_out), 80'd0);
        check({tag, "_rk_idx"}, 80'(bus.rk_idx), 80'd0);
        check({tag, "_rk_valid"}, 80'(bus.rk_valid), 80'd0);
        check({tag, "_rk_last"}, 80'(bus.rk_last), 80'd0);
        check({tag, "_busy"}, 80'(bus.busy), 80'd0);
        check({tag, "_key_ready"}, 80'(bus.key_ready), 80'd1);
    endtask

    task automatic send_key(input key_t key);
        @(negedge clock);
        bus.key_in    = key;
        bus.key_valid = 1'b1;
        check("key_ready_idle", 80'(bus.key_ready), 80'd1);
        push_expect(key);
        @(posedge clock);
        #1;
        bus.key_valid = 1'b0;
        check("busy_expand", 80'(bus.busy), 80'd1);
        check("key_ready_expand", 80'(bus.key_ready), 80'd0);
    endtask

    // Counts edges from the key handshake to the first rk_valid.
    task automatic wait_valid(input logic pulse, input key_t pulse_key);
        int n = 0;
        while (!bus.rk_valid && n < 100) begin
            if (pulse) begin
                bus.key_valid = (n == 10);
                bus.key_in    = pulse_key;
                if (n == 10) check("key_ready_pulse_expand", 80'(bus.key_ready), 80'd0);
            end
            @(posedge clock);
            n++;
            #1;
        end
        if (pulse) bus.key_valid = 1'b0;
        check("first_valid_latency", 80'(n), 80'd32);
    endtask

    task automatic drain(input int ready_pct, input int stop_idx, input logic pulse,
                         input key_t pulse_key);
        int   guard = 0;
        logic fin = 1'b0;
        logic prev_stall = 1'b0;
        rk_t  prev_rk = '0;
        logic [5:0] prev_idx = '0;
        exp_t e;
        while (!fin && guard < 2000) begin
            @(negedge clock);
            guard++;
            if (prev_stall) begin
                check("stall_valid", 80'(bus.rk_valid), 80'd1);
                check("stall_rk_out", 80'(bus.rk_out), 80'(prev_rk));
                check("stall_rk_idx", 80'(bus.rk_idx), 80'(prev_idx));
            end
            if (bus.rk_valid && stop_idx != 0 && int'(bus.rk_idx) == stop_idx) begin
                bus.rk_ready = 1'b0;
                fin = 1'b1;
            end else begin
                bus.rk_ready = ($urandom_range(99) < ready_pct);
                if (pulse) begin
                    bus.key_valid = bus.rk_valid && (bus.rk_idx == 6'd20);
                    bus.key_in    = pulse_key;
                    if (bus.key_valid) check("key_ready_pulse_emit", 80'(bus.key_ready), 80'd0);
                end
                if (bus.rk_valid && bus.rk_ready) begin
                    if (sb.size() == 0) begin
                        check("scoreboard_underflow", 80'(bus.rk_idx), 80'd0);
                        fin = 1'b1;
                    end else begin
                        e = sb.pop_front();
                        check("rk_out", 80'(bus.rk_out), 80'(e.rk));
                        check("rk_idx", 80'(bus.rk_idx), 80'(e.idx));
                        check("rk_last", 80'(bus.rk_last), 80'(e.last));
                        if (bus.rk_idx == 6'd2) got_rk2 = bus.rk_out;
                        if (bus.rk_last) begin
                            got_rk1 = bus.rk_out;
                            fin = 1'b1;
                        end
                    end
                end
                prev_stall = bus.rk_valid && !bus.rk_ready;
                prev_rk    = bus.rk_out;
                prev_idx   = bus.rk_idx;
            end
        end
        if (pulse) bus.key_valid = 1'b0;
        check("drain_finished", 80'(fin), 80'd1);
    endtask

    task automatic post_checks(input key_t key);
        @(posedge clock);
        #1;
        bus.rk_ready = 1'b0;
        check("post_key_ready", 80'(bus.key_ready), 80'd1);
        check("post_busy", 80'(bus.busy), 80'd0);
        check("post_rk_valid", 80'(bus.rk_valid), 80'd0);
        check("post_k_restored", dut.k_q, key);
        check("post_sb_empty", 80'(sb.size()), 80'd0);
    endtask

    task automatic run_key(input key_t key, input int ready_pct);
        send_key(key);
        bus.rk_ready = 1'b1;
        wait_valid(1'b0, '0);
        drain(ready_pct, 0, 1'b0, '0);
        post_checks(key);
    endtask

    task automatic async_reset(input string tag);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals(tag);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        key_t k;
        key_t kd;
        n_assert      = 0;
        n_fail        = 0;
        reset_n       = 1'b1;
        bus.key_in    = '0;
        bus.key_valid = 1'b0;
        bus.rk_ready  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // All-zero key with the consumer always ready.
        run_key('0, 100);
        check("zero_rk2", 80'(got_rk2), 80'(64'hC000000000000000));
        check("zero_rk1", 80'(got_rk1), 80'd0);

        // All-ones key.
        run_key({80{1'b1}}, 100);
        check("ones_rk1", 80'(got_rk1), 80'(64'hFFFFFFFFFFFFFFFF));

        // Random keys under random backpressure.
        for (int i = 0; i < 3; i++) begin
            k = {$urandom(), $urandom(), 16'($urandom())};
            run_key(k, 50);
        end

        // Second key offered mid-EXPAND and mid-EMIT must be ignored.
        k = 80'h0123_4567_89AB_CDEF_1357;
        send_key(k);
        bus.rk_ready = 1'b1;
        wait_valid(1'b1, 80'hDEAD_BEEF_0000_FFFF_AAAA);
        drain(70, 0, 1'b1, 80'hDEAD_BEEF_0000_FFFF_AAAA);
        post_checks(k);

        // Reset at the EXPAND midpoint, then at rk_idx 17, then a clean key.
        send_key(80'h1111_2222_3333_4444_5555);
        repeat (15) @(posedge clock);
        async_reset("rst_expand");
        send_key(80'h6666_7777_8888_9999_AAAA);
        bus.rk_ready = 1'b1;
        wait_valid(1'b0, '0);
        drain(100, 17, 1'b0, '0);
        async_reset("rst_emit");
        run_key(80'hFEDC_BA98_7654_3210_0F0F, 100);

        // Back-to-back keys with key_valid held high across the first stream.
        k  = 80'hA5A5_5A5A_C3C3_3C3C_9696;
        kd = 80'h0F1E_2D3C_4B5A_6978_8796;
        send_key(k);
        bus.rk_ready  = 1'b1;
        wait_valid(1'b0, '0);
        bus.key_in    = kd;
        bus.key_valid = 1'b1;
        drain(100, 0, 1'b0, '0);
        @(posedge clock);
        #1;
        check("b2b_key_ready", 80'(bus.key_ready), 80'd1);
        check("b2b_busy_low", 80'(bus.busy), 80'd0);
        check("b2b_first_restored", dut.k_q, k);
        check("b2b_sb_empty", 80'(sb.size()), 80'd0);
        push_expect(kd);
        @(posedge clock);
        #1;
        bus.key_valid = 1'b0;
        check("b2b_busy_high", 80'(bus.busy), 80'd1);
        check("b2b_key_ready_low", 80'(bus.key_ready), 80'd0);
        wait_valid(1'b0, '0);
        drain(100, 0, 1'b0, '0);
        post_checks(kd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
